commit_arbiter: RTL
===================

COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths come from the shared cpu.svh types.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  pipeline flush; synchronous, same clearing effect as reset on datapath state.
REQ-005 fu0_to_valid  input  1  execute unit 0 holds a valid result.
REQ-006 fu0_to_commit_bus  input  execute_to_commit_bus_t  execute unit 0 result.
REQ-007 fu0_cs_allowin  output  1  commit side accepts fu0 result this cycle.
REQ-008 fu1_to_valid, fu1_to_commit_bus, fu1_cs_allowin SHALL be identical to REQ-005..007 for execute unit 1.
REQ-009 rob_allowin  input  1  ROB writeback port can take the registered result.
REQ-010 rob_wb_valid  output  1  registered result valid.
REQ-011 rob_wb_bus  output  execute_to_commit_bus_t  registered result; .valid field equals rob_wb_valid.

Function
REQ-012 Transfer on port i SHALL occur when fui_to_valid && fui_cs_allowin; the FU holds valid and bus stable until then.
REQ-013 Output stage SHALL be "free" when !rob_wb_valid || rob_allowin; the output register loads only when free.
REQ-014 When the output stage is not free or flush is high, both fui_cs_allowin SHALL be 0.
REQ-015 When free and exactly one port is valid, that port SHALL be granted (allowin=1) and the other SHALL get allowin=0.
REQ-016 When free and both are valid, the port selected by the 1-bit rr_ptr SHALL be granted; the other SHALL be held.
REQ-017 rr_ptr SHALL be set to the index of the non-granted port after every grant; it SHALL stay unchanged when no grant occurs.
REQ-018 Held port SHALL be granted no later than the next free cycle (max one lost arbitration).
REQ-019 fui_cs_allowin SHALL be combinational from fui_to_valid, rr_ptr, rob_wb_valid, rob_allowin and flush; at most one allowin SHALL be 1 per cycle.
REQ-020 Latency SHALL be one cycle: a grant in cycle N gives rob_wb_valid=1 with the granted bus in cycle N+1.
REQ-021 When free and no port is valid, rob_wb_valid SHALL go to 0 next cycle.
REQ-022 All bus fields, including exception, SHALL pass unmodified; only .valid is regenerated.
REQ-023 Back-to-back throughput SHALL be one result per cycle while rob_allowin stays 1.
REQ-024 If rob_allowin=0 while rob_wb_valid=1, rob_wb_bus SHALL hold its value; no input is lost.
REQ-025 flush SHALL clear rob_wb_valid next cycle, discard any result pending in the output register, and grant nothing in the flush cycle.

Reset
REQ-026 On reset: rob_wb_valid=0, rob_wb_bus=0, rr_ptr=0 (port 0 wins first tie), stats counters=0.
REQ-027 Reset asserted mid-transfer SHALL win over any grant in that cycle; allowin outputs SHALL be 0 while reset is high.
REQ-028 flush SHALL reset rr_ptr to 0 and leave the stats counters unchanged.

Configuration
REQ-029 Macro COMMIT_ARB_STATS_EN: when defined, adds outputs stat_conflict_cnt (32 bits; cycles with both ports valid and the output free) and stat_rob_stall_cnt (32 bits; cycles with rob_wb_valid && !rob_allowin).
REQ-030 The stats counters SHALL wrap modulo 2^32 and SHALL NOT affect arbitration.
REQ-031 When the macro is undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then fu0 alone with result=32'h1234, rob_entry_num=3 -> fu0_cs_allowin=1 same cycle; next cycle rob_wb_valid=1, result=32'h1234, rob_entry_num=3.
REQ-033 Both valid for 3 cycles with rob_allowin=1, after reset -> grants fu0, fu1, fu0; rob_entry_num sequence on the output follows that order.
REQ-034 rob_allowin=0 for 2 cycles with output holding entry 5 and fu1 valid -> both allowins 0, output holds 5; rob_allowin=1 -> fu1 granted, output shows fu1 next cycle.
REQ-035 flush in the same cycle as fu0 valid and output valid -> no allowin, rob_wb_valid=0 next cycle, rr_ptr=0.
REQ-036 fu1 result with exception.ex=1, exccode=OV -> output carries ex=1, OV unchanged one cycle later.
REQ-037 With COMMIT_ARB_STATS_EN defined: 4 conflict cycles plus 2 ROB stall cycles -> stat_conflict_cnt=4 and stat_rob_stall_cnt=2; with the macro undefined, the same stimulus gives an identical output trace.

Source files
------------

// File: rtl/commit_arbiter.sv
// ============================================================================
// commit_arbiter : two-port round-robin arbiter feeding one registered ROB
// writeback stage. Optional macro COMMIT_ARB_STATS_EN adds stats counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;
  localparam logic [4:0] EXC_OV = 5'h0c;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  rob_entry_num;
    logic [31:0] result;
    logic [4:0]  dest;
    exception_t  exception;
  } execute_to_commit_bus_t;
endpackage

module commit_arbiter
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fu0_to_valid,
  input  execute_to_commit_bus_t fu0_to_commit_bus,
  output logic                   fu0_cs_allowin,
  input  logic                   fu1_to_valid,
  input  execute_to_commit_bus_t fu1_to_commit_bus,
  output logic                   fu1_cs_allowin,
  input  logic                   rob_allowin,
  output logic                   rob_wb_valid,
  output execute_to_commit_bus_t rob_wb_bus
`ifdef COMMIT_ARB_STATS_EN
  ,
  output logic [31:0]            stat_conflict_cnt,
  output logic [31:0]            stat_rob_stall_cnt
`endif
);

  logic                   rr_ptr_q, rr_ptr_d;
  logic                   wb_valid_q, wb_valid_d;
  execute_to_commit_bus_t wb_bus_q, wb_bus_d;
  logic                   out_free;
  logic                   grant0;
  logic                   grant1;

  // rr_ptr names the port that wins when both are valid.
  always_comb begin
    out_free = !wb_valid_q || rob_allowin;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (out_free && !flush && !reset) begin
      if (fu0_to_valid && (!fu1_to_valid || !rr_ptr_q)) begin
        grant0 = 1'b1;
      end else if (fu1_to_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = wb_valid_q;
    wb_bus_d   = wb_bus_q;
    if (flush) begin
      rr_ptr_d   = 1'b0;
      wb_valid_d = 1'b0;
      wb_bus_d   = '0;
    end else if (out_free) begin
      wb_valid_d = grant0 || grant1;
      if (grant0) begin
        wb_bus_d = fu0_to_commit_bus;
        rr_ptr_d = 1'b1;
      end else if (grant1) begin
        wb_bus_d = fu1_to_commit_bus;
        rr_ptr_d = 1'b0;
      end else begin
        wb_bus_d = '0;
      end
      wb_bus_d.valid = grant0 || grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_bus_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_bus_q   <= wb_bus_d;
    end
  end

  assign fu0_cs_allowin = grant0;
  assign fu1_cs_allowin = grant1;
  assign rob_wb_valid   = wb_valid_q;
  assign rob_wb_bus     = wb_bus_q;

`ifdef COMMIT_ARB_STATS_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters only observe; flush does not clear them.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q + {31'd0, (fu0_to_valid && fu1_to_valid && out_free)};
    stall_cnt_d    = stall_cnt_q + {31'd0, (wb_valid_q && !rob_allowin)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign stat_conflict_cnt  = conflict_cnt_q;
  assign stat_rob_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
